rr_mux_reg: RTL
===============

Name: rr_mux_reg

Overview:
- Parametrised, registered N:1 datapath multiplexer with valid/ready handshakes on every input channel and on the output.
- Successor to the fixed 4:1 combinational 32-bit mux. Adds generic width and channel count, a registered output stage, and two selection modes: externally selected, or round-robin arbitrated.
- Sits between multiple producers (e.g. pipeline-stage writeback sources) and a single consumer.

Parameters:
- WIDTH, 32, data width per channel in bits
- NUM_CH, 4, number of input channels; must be at least 2
- SEL_W, $clog2(NUM_CH), width of the select and channel-index fields (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration
- sel  input  SEL_W  channel index used when mode=0; values at or above NUM_CH select nothing
- in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  index of the channel that produced out_data
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset values (asynchronous): out_valid=0, out_data=0, out_ch=0, round-robin pointer rr_ptr=0.
- load = !out_valid | out_ready. The output register can take a new beat in any cycle where load=1, which gives full throughput of one beat per cycle.
- Grant (combinational):
  - mode=0: grant = onehot(sel) if sel < NUM_CH and in_valid[sel]=1; otherwise zero. Requests on other channels are ignored and never granted.
  - mode=1: grant = the first set bit of in_valid, scanning rr_ptr, rr_ptr+1, ... NUM_CH-1, 0, ... with wrap-around.
- in_ready = grant when load=1; otherwise all zeros. A channel's transfer occurs when in_valid[i] & in_ready[i].
- On a transfer from channel g:
  - next edge: out_valid=1, out_data=in_data[g], out_ch=g.
  - in mode=1 only, rr_ptr <= (g+1) mod NUM_CH.
- rr_ptr is held while mode=0, and held when there is no transfer.
- load=1 with no grant: out_valid <= 0 on the next edge. out_data and out_ch hold their last values.
- out_valid=1 and out_ready=0: out_data and out_ch are stable and all in_ready are 0 (backpressure).
- Latency: a beat accepted at edge n is visible at the outputs after edge n and consumed at the first edge where out_ready=1.
- Mode or sel may change on any cycle; they take effect combinationally for the current grant. A beat already in the output register is not affected.
- Asserting reset mid-operation drops any buffered beat. No in_ready is asserted while reset=1.
- No combinational path from in_data to out_data. out_ready and in_valid do reach in_ready combinationally.

Decomposition:
- Shared package holds the mode encoding constants (MODE_FIXED=1'b0, MODE_RR=1'b1).
- One sub-module, rr_arbiter: inputs req[NUM_CH] and ptr[SEL_W]; output grant one-hot. Purely combinational; rotate, priority-pick, rotate back.
- Top level holds rr_ptr, the output register, and the mode-0 select decode.

Test Plan:
- Reset mid-stream: with out_valid=1, assert reset -> out_valid=0, out_data=0, out_ch=0 immediately; rr_ptr=0 after release.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, data = F0F0F0F0/F8F8F8F8/FBFBFBFB/FFFFFFFF, out_ready=1 -> in_ready=4'b0100 each cycle; out_data=FBFBFBFB, out_ch=2 from the next cycle.
- Round-robin fairness: mode=1, all four valid, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; one beat per cycle.
- Sparse requests with wrap: mode=1, rr_ptr=3, in_valid=4'b0011 -> grant channel 0, then rr_ptr=1 and channel 1 is granted next.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_ch stable, in_ready=0; on out_ready=1, a new beat is loaded at the same edge.
- Invalid select: mode=0, sel=2, in_valid=4'b1011 -> in_ready=0; out_valid drops to 0 after the pending beat drains.

Source files
------------

// File: rtl/rr_mux_reg_pkg.sv
// rr_mux_reg_pkg: shared definitions for the registered round-robin multiplexer.
//   - Mode encoding constants for the 'mode' input of rr_mux_reg.
//   - Small helpers shared by the top level and the arbiter.
package rr_mux_reg_pkg;

  // Selection mode encoding
  localparam logic MODE_FIXED = 1'b0;  // channel chosen by 'sel'
  localparam logic MODE_RR    = 1'b1;  // round-robin arbitration over in_valid

  // True when the given mode selects round-robin arbitration.
  function automatic logic is_rr_mode(input logic mode);
    return mode == MODE_RR;
  endfunction

endpackage : rr_mux_reg_pkg

// File: rtl/rr_mux_reg_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   Ports:
//     req   [NUM_CH]  request vector, bit i belongs to channel i
//     ptr   [SEL_W]   highest-priority channel for this cycle (must be < NUM_CH)
//     grant [NUM_CH]  one-hot grant, zero when no request is set
//   Scheme: rotate requests so 'ptr' lands at bit 0, take the lowest set bit,
//   rotate the pick back to channel positions.
module rr_arbiter
  import rr_mux_reg_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [2*NUM_CH-1:0] pick_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic [NUM_CH-1:0]   pick_rot;
  logic                found;

  always_comb begin
    req_dbl  = '0;
    pick_dbl = '0;
    req_rot  = '0;
    pick_rot = '0;
    found    = 1'b0;
    grant    = '0;

    // Doubling the vector turns the rotation into a plain shift, which also
    // works when NUM_CH is not a power of two.
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_CH-1:0];

    for (int i = 0; i < NUM_CH; i++) begin
      if (req_rot[i] && !found) begin
        pick_rot[i] = 1'b1;
        found       = 1'b1;
      end
    end

    // Rotate back: upper half of the left-shifted doubled pick holds
    // channel positions.
    pick_dbl = {pick_rot, pick_rot} << ptr;
    grant    = pick_dbl[2*NUM_CH-1:NUM_CH];
  end

endmodule : rr_arbiter

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N:1 datapath multiplexer with valid/ready handshakes.
//   Selection is either fixed (mode=MODE_FIXED, channel 'sel') or round-robin
//   (mode=MODE_RR, pointer advances past each granted channel).
//   Ports:
//     clk, reset            rising-edge clock, asynchronous active-high reset
//     mode                  0 = fixed select via sel, 1 = round-robin
//     sel       [SEL_W]     channel index for fixed mode; >= NUM_CH selects nothing
//     in_valid  [NUM_CH]    per-channel request
//     in_data   [NUM_CH*WIDTH] packed data, channel i at [i*WIDTH +: WIDTH]
//     in_ready  [NUM_CH]    per-channel accept, one-hot or zero
//     out_valid             output register holds a beat
//     out_data  [WIDTH]     registered data
//     out_ch    [SEL_W]     source channel of out_data
//     out_ready             consumer accepts the beat
//   NUM_CH must be at least 2; SEL_W is derived and must not be overridden.
module rr_mux_reg
  import rr_mux_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  logic              out_valid_d, out_valid_q;
  logic [WIDTH-1:0]  out_data_d,  out_data_q;
  logic [SEL_W-1:0]  out_ch_d,    out_ch_q;
  logic [SEL_W-1:0]  rr_ptr_d,    rr_ptr_q;

  logic              load;
  logic [NUM_CH-1:0] fixed_grant;
  logic [NUM_CH-1:0] rr_grant;
  logic [NUM_CH-1:0] grant;
  logic              xfer;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant)
  );

  // Output stage can take a beat when empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  // Fixed-mode decode: sel values with no matching channel never hit.
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        fixed_grant[i] = 1'b1;
      end
    end
  end

  assign grant = is_rr_mode(mode) ? rr_grant : fixed_grant;

  // Grant is one-hot, so OR-reduction gives index and data directly.
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        grant_idx  = grant_idx  | SEL_W'(i);
        grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset blocks acceptance so no beat is lost to a flop held in reset.
  assign in_ready = (load && !reset) ? grant : '0;
  assign xfer     = |(in_ready & in_valid);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;

    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
      end
    end

    if (xfer && is_rr_mode(mode)) begin
      if (grant_idx == SEL_W'(NUM_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule : rr_mux_reg
